// File: rtl/whack_judge.sv
// Per-mole hit/miss judge: synchronises and edge-detects the five game keys, times each
// mole's hit window, and counts misses up to a sticky game_lose.
module whack_judge #(
  parameter int WINDOW_TICKS   = 1000,
  parameter int CNT_W          = 10,
  parameter int MAX_MISSES     = 3,
  parameter int WRONG_KEY_MISS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       mole_load,
  input  logic [2:0] mole_pos,
  input  logic [4:0] keys,
  input  logic       restart,
  output logic       correct_whack,
  output logic       miss_pulse,
  output logic [1:0] misses,
  output logic       mole_active,
  output logic       game_lose
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE, LOST} state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_TICKS - 1);
  localparam logic [2:0]       MAX_M    = 3'(MAX_MISSES);

  state_e           state_q, state_d;
  logic [4:0]       s1_q, s2_q, s3_q, press;
  logic [2:0]       pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       misses_q, misses_d;
  logic             cw_q, cw_d, mp_q, mp_d, lose_q, lose_d;

  logic       valid_load, correct, wrong, hit, key_miss, timeout, miss;
  logic [4:0] tgt;
  logic [2:0] miss_inc;

  // s1/s2 resynchronise the raw levels, s3 remembers the previous level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= keys;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign press = s2_q & ~s3_q;

  always_comb begin
    tgt = '0;
    case (pos_q)
      3'd1: tgt = 5'b00001;
      3'd2: tgt = 5'b00010;
      3'd3: tgt = 5'b00100;
      3'd4: tgt = 5'b01000;
      3'd5: tgt = 5'b10000;
      default: tgt = '0;
    endcase
  end

  assign valid_load = mole_load && (mole_pos >= 3'd1) && (mole_pos <= 3'd5);
  assign correct    = |(press & tgt);
  assign wrong      = |(press & ~tgt);
  assign hit        = correct & ~wrong;
  assign key_miss   = wrong & ((WRONG_KEY_MISS != 0) | correct);
  assign timeout    = tick && (cnt_q == LAST_CNT);
  assign miss_inc   = {1'b0, misses_q} + 3'd1;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    misses_d = misses_q;
    lose_d   = lose_q;
    cw_d     = 1'b0;
    mp_d     = 1'b0;
    miss     = 1'b0;
    if (restart) begin
      state_d  = IDLE;
      misses_d = '0;
      lose_d   = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: if (valid_load) begin
          state_d = ARMED;
          pos_d   = mole_pos;
          cnt_d   = '0;
        end
        ARMED: begin
          if (hit) begin
            cw_d    = 1'b1;
            state_d = DONE;
          end else if (key_miss || timeout || valid_load) begin
            miss    = 1'b1;
            state_d = DONE;
          end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
          end
          // a replacement mole re-arms immediately; the old one was resolved above
          if (valid_load) begin
            state_d = ARMED;
            pos_d   = mole_pos;
            cnt_d   = '0;
          end
          if (miss) begin
            mp_d = 1'b1;
            if (miss_inc >= MAX_M) begin
              misses_d = MAX_M[1:0];
              lose_d   = 1'b1;
              state_d  = LOST;
            end else begin
              misses_d = miss_inc[1:0];
            end
          end
        end
        DONE: if (valid_load) begin
          state_d = ARMED;
          pos_d   = mole_pos;
          cnt_d   = '0;
        end else if (mole_load) begin
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      cnt_q    <= '0;
      misses_q <= '0;
      cw_q     <= 1'b0;
      mp_q     <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      misses_q <= misses_d;
      cw_q     <= cw_d;
      mp_q     <= mp_d;
      lose_q   <= lose_d;
    end
  end

  assign correct_whack = cw_q;
  assign miss_pulse    = mp_q;
  assign misses        = misses_q;
  assign game_lose     = lose_q;
  assign mole_active   = (state_q == ARMED);

endmodule

// File: tb/tb_whack_judge.sv
// Scoreboard bench for whack_judge: stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_whack_judge;
  localparam int WT = 4;

  logic       clk = 1'b0, rst_n = 1'b1, tick = 1'b0, mole_load = 1'b0, restart = 1'b0;
  logic [2:0] mole_pos = '0;
  logic [4:0] keys = '0;
  logic       correct_whack, miss_pulse, mole_active, game_lose;
  logic [1:0] misses;

  whack_judge #(.WINDOW_TICKS(WT), .CNT_W(2), .MAX_MISSES(3), .WRONG_KEY_MISS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mole_load(mole_load), .mole_pos(mole_pos),
    .keys(keys), .restart(restart), .correct_whack(correct_whack), .miss_pulse(miss_pulse),
    .misses(misses), .mole_active(mole_active), .game_lose(game_lose)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct {
    bit         hit;
    int         cyc;
    logic [1:0] misses;
    bit         lose;
  } exp_t;
  exp_t sb[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(bit h, int c, logic [1:0] m, bit l);
    exp_t e;
    e.hit = h; e.cyc = c; e.misses = m; e.lose = l;
    sb.push_back(e);
  endtask

  task automatic load(logic [2:0] p);
    mole_pos = p; mole_load = 1'b1; step(1); mole_load = 1'b0;
  endtask

  // key driven now is sampled at the next edge; the judged pulse lands two edges later
  task automatic press_key(logic [4:0] k, bit h, logic [1:0] m, bit l);
    keys = k; push(h, cyc + 3, m, l); step(3); keys = '0; step(3);
  endtask

  task automatic timeout_mole(logic [2:0] p, logic [1:0] m, bit l);
    load(p); tick = 1'b1; step(WT - 1);
    push(1'b0, cyc + 1, m, l); step(1); tick = 1'b0; step(1);
  endtask

  task automatic do_restart();
    restart = 1'b1; step(1); restart = 1'b0;
    chk("restart_misses", misses, 0);
    chk("restart_lose", game_lose, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (correct_whack || miss_pulse)) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: got cw=%0d mp=%0d at cycle %0d, expected none",
                 correct_whack, miss_pulse, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, correct_whack, miss_pulse}, e.hit ? 32'd2 : 32'd1);
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_misses", misses, e.misses);
        chk("pulse_lose", game_lose, e.lose);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cw", correct_whack, 0);
    chk("rst_mp", miss_pulse, 0);
    chk("rst_misses", misses, 0);
    chk("rst_active", mole_active, 0);
    chk("rst_lose", game_lose, 0);
    step(2); rst_n = 1'b1; step(1);

    // W hit: one-cycle correct_whack, mole_active falls on the same edge
    load(3'd2);
    chk("armed_w", mole_active, 1);
    keys = 5'b00010; push(1'b1, cyc + 3, 2'd0, 1'b0); step(3);
    chk("hit_cw_high", correct_whack, 1);
    chk("hit_active_low", mole_active, 0);
    step(1);
    chk("hit_cw_one_cycle", correct_whack, 0);
    keys = '0; step(3);

    // plain timeout
    timeout_mole(3'd1, 2'd1, 1'b0);
    chk("timeout_active", mole_active, 0);
    chk("timeout_misses", misses, 1);

    // correct plus wrong key together
    load(3'd3);
    press_key(5'b01100, 1'b0, 2'd2, 1'b0);
    do_restart();

    // hit on the timeout tick wins
    load(3'd4); tick = 1'b1; step(WT - 1); tick = 1'b0;
    keys = 5'b01000; step(2);
    tick = 1'b1; push(1'b1, cyc + 1, 2'd0, 1'b0); step(1); tick = 1'b0;
    keys = '0; step(3);

    // wrong key alone
    load(3'd5);
    press_key(5'b00001, 1'b0, 2'd1, 1'b0);

    // replacement mole while armed: old one missed, new one hittable
    load(3'd1);
    mole_pos = 3'd2; mole_load = 1'b1; push(1'b0, cyc + 1, 2'd2, 1'b0); step(1); mole_load = 1'b0;
    chk("reload_active", mole_active, 1);
    press_key(5'b00010, 1'b1, 2'd2, 1'b0);
    do_restart();

    // invalid code leaves IDLE
    load(3'd6);
    chk("invalid_idle", mole_active, 0);

    // three timeouts to LOST
    timeout_mole(3'd1, 2'd1, 1'b0);
    timeout_mole(3'd2, 2'd2, 1'b0);
    timeout_mole(3'd3, 2'd3, 1'b1);
    chk("lost_lose", game_lose, 1);
    load(3'd1);
    chk("lost_no_arm", mole_active, 0);
    keys = 5'b00001; tick = 1'b1; step(3); keys = '0; tick = 1'b0; step(3);
    chk("lost_misses", misses, 3);
    chk("lost_sticky", game_lose, 1);

    do_restart();
    load(3'd2);
    press_key(5'b00010, 1'b1, 2'd0, 1'b0);

    // reset while a hit pulse is high and the key is held
    load(3'd1);
    keys = 5'b00001; push(1'b1, cyc + 3, 2'd0, 1'b0); step(3);
    #5;
    rst_n = 1'b0; #1;
    chk("async_cw", correct_whack, 0);
    chk("async_active", mole_active, 0);
    step(2); rst_n = 1'b1; step(6);
    chk("post_rst_idle", mole_active, 0);
    load(3'd1); step(6);
    chk("held_no_press", mole_active, 1);
    keys = '0; step(3);
    press_key(5'b00001, 1'b1, 2'd0, 1'b0);

    step(5);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
